// File: rtl/clock_divider.sv
// Two free-running 50%-duty integer clock dividers (mclk, slow_clk) from clk.
// Odd ratios OR a rising-edge register with its falling-edge resample to get N/2 high time.

module clock_divider_core #(
  parameter int N = 4
) (
  input  logic rst,
  input  logic clk,
  output logic clk_out
);
  localparam int W = (N < 2) ? 1 : $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] HALF = W'(N / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pos_q, pos_d;

  // Output is registered from the next count, so the first edge after reset
  // (count 0 -> 1) raises it; high for counts 1..floor(N/2).
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    pos_d = (cnt_d != '0) && (cnt_d <= HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

  if (N < 2) begin : g_bad
    $fatal(1, "clock_divider_core: ratio N=%0d must be >= 2", N);
    assign clk_out = 1'b0;
  end else if ((N % 2) == 1) begin : g_odd
    logic neg_q, neg_d;

    always_comb neg_d = pos_q;

    always_ff @(negedge clk or posedge rst) begin
      if (rst) neg_q <= 1'b0;
      else     neg_q <= neg_d;
    end

    // pos_q and neg_q overlap by half a cycle, so the OR cannot glitch
    assign clk_out = pos_q | neg_q;
  end else begin : g_even
    assign clk_out = pos_q;
  end
endmodule

module clock_divider #(
  parameter int MCLK_DIV = 4,
  parameter int SLOW_DIV = 1000000
) (
  input  logic rst,
  input  logic clk,
  output logic mclk,
  output logic slow_clk
);
  clock_divider_core #(.N(MCLK_DIV)) u_mclk_div (
    .rst     (rst),
    .clk     (clk),
    .clk_out (mclk)
  );

  clock_divider_core #(.N(SLOW_DIV)) u_slow_div (
    .rst     (rst),
    .clk     (clk),
    .clk_out (slow_clk)
  );
endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: four ratio pairs share clk/rst, checked each half-cycle
// against a model counting half-periods since the first rising edge after reset.
`timescale 1ns/1ps
module tb_clock_divider;
  logic clk = 1'b0;
  logic rst;
  logic ma, sa, mb, sb, mc, sc, md, sd;

  int total = 0;
  int bad   = 0;
  int h     = -1;

  clock_divider #(.MCLK_DIV(4), .SLOW_DIV(8))  u_a (.rst(rst), .clk(clk), .mclk(ma), .slow_clk(sa));
  clock_divider #(.MCLK_DIV(2), .SLOW_DIV(6))  u_b (.rst(rst), .clk(clk), .mclk(mb), .slow_clk(sb));
  clock_divider #(.MCLK_DIV(3), .SLOW_DIV(7))  u_c (.rst(rst), .clk(clk), .mclk(mc), .slow_clk(sc));
  clock_divider #(.MCLK_DIV(5), .SLOW_DIV(10)) u_d (.rst(rst), .clk(clk), .mclk(md), .slow_clk(sd));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp_m;
  } vec_t;

  // Ideal divided clock: high for the first N half-periods of every 2N.
  function automatic logic model(input int n, input int hh);
    if (hh < 0) return 1'b0;
    return ((hh % (2 * n)) < n);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t h=%0d: got %b want %b", name, $time, h, act, exp);
    end
  endtask

  task automatic check_all();
    chk("mclk_a", ma, model(4, h));  chk("slow_a", sa, model(8, h));
    chk("mclk_b", mb, model(2, h));  chk("slow_b", sb, model(6, h));
    chk("mclk_c", mc, model(3, h));  chk("slow_c", sc, model(7, h));
    chk("mclk_d", md, model(5, h));  chk("slow_d", sd, model(10, h));
  endtask

  task automatic step();
    @(clk);
    #2;
    if (!rst) h++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2;
    rst = 1'b0;
    h   = -1;
  endtask

  task automatic hit_rst(input int d);
    #(d);
    rst = 1'b1;
    h   = -1;
    #1;
    check_all();
  endtask

  vec_t tbl[10];
  logic prev_mb, prev_sb;
  int   hc_m, hc_s;
  int   guard;

  initial begin
    tbl[0].exp_m = 4'b1111; tbl[1].exp_m = 4'b1111;
    tbl[2].exp_m = 4'b1011; tbl[3].exp_m = 4'b1001;
    tbl[4].exp_m = 4'b0101; tbl[5].exp_m = 4'b0100;
    tbl[6].exp_m = 4'b0010; tbl[7].exp_m = 4'b0010;
    tbl[8].exp_m = 4'b1110; tbl[9].exp_m = 4'b1100;

    rst = 1'b0;
    #1 rst = 1'b1;

    // Power-up reset held for 5 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      check_all();
    end
    release_rst();

    // Directed phase table for the four mclk ratios {4,2,3,5}
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({ma, mb, mc, md} !== tbl[i].exp_m) begin
        bad++;
        $display("FAIL tbl[%0d] mclk_abcd got %b want %b", i, {ma, mb, mc, md}, tbl[i].exp_m);
      end
    end

    // Long run with slow_b / mclk_b rising-edge alignment
    prev_mb = mb;
    prev_sb = sb;
    for (int i = 0; i < 80; i++) begin
      step();
      check_all();
      if (sb && !prev_sb) chk("align_b", mb && !prev_mb, 1'b1);
      prev_mb = mb;
      prev_sb = sb;
    end

    // Mid-operation reset while mclk_a is high
    guard = 0;
    while (ma !== 1'b1 && guard < 16) begin
      step();
      guard++;
    end
    chk("find_mclk_a_high", ma, 1'b1);
    hit_rst(1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_all();
    end
    release_rst();
    step();
    total++;
    if ({ma, sa, mb, sb, mc, sc, md, sd} !== 8'hFF) begin
      bad++;
      $display("FAIL restart_in_phase got %b want 11111111", {ma, sa, mb, sb, mc, sc, md, sd});
    end

    // 50% duty on ratio 3 and 7 over 42 cycles (84 half-cycles incl. the one above)
    hc_m = 1;
    hc_s = 1;
    for (int i = 1; i < 84; i++) begin
      step();
      check_all();
      if (mc) hc_m++;
      if (sc) hc_s++;
    end
    total++;
    if (hc_m != 42) begin
      bad++;
      $display("FAIL duty_mclk_c high_halves got %0d want 42", hc_m);
    end
    total++;
    if (hc_s != 42) begin
      bad++;
      $display("FAIL duty_slow_c high_halves got %0d want 42", hc_s);
    end

    // Randomised run lengths and asynchronous reset timing
    for (int r = 0; r < 20; r++) begin
      int run_len;
      int hold;
      run_len = $urandom_range(5, 60);
      hold    = $urandom_range(1, 6);
      for (int i = 0; i < run_len; i++) begin
        step();
        check_all();
      end
      hit_rst($urandom_range(0, 1));
      for (int i = 0; i < hold; i++) begin
        step();
        check_all();
      end
      release_rst();
    end
    for (int i = 0; i < 20; i++) begin
      step();
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
